// File: rtl/coz_yazmac_puantaj.sv
// coz_yazmac_puantaj: register file with integrated write scoreboard for the
// decode/register-read stage. Reads are combinational with writeback bypass;
// a per-register pending-write counter drives RAW hazard and issue decisions.
// Optional build macro: COZ_PUANTAJ_SAYAC_EN adds saturating stall/issue
// cycle counters (durdur_sayac_o, kabul_sayac_o).
module coz_yazmac_puantaj #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned YAZMAC_SAYISI = 32,
    parameter int unsigned ADRES_BIT     = 5,
    parameter int unsigned OKUMA_PORT    = 2,
    parameter int unsigned SAYAC_BIT     = 2
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [OKUMA_PORT*ADRES_BIT-1:0] oku_adres_i,
    input  logic [OKUMA_PORT-1:0]           oku_kullan_i,
    output logic [OKUMA_PORT*XLEN-1:0]      oku_deger_o,
    output logic [OKUMA_PORT-1:0]           oku_mesgul_o,
    input  logic                            buyruk_gecerli_i,
    input  logic                            rd_yaz_i,
    input  logic [ADRES_BIT-1:0]            rd_adres_i,
    output logic                            kabul_o,
    output logic                            puantaj_durdur_o,
    input  logic                            ddb_durdur_i,
    input  logic                            ddb_bosalt_i,
    input  logic                            gy_yaz_yazmac_i,
    input  logic [ADRES_BIT-1:0]            gy_yaz_adres_i,
    input  logic [XLEN-1:0]                 gy_yaz_deger_i,
    output logic                            hata_o
`ifdef COZ_PUANTAJ_SAYAC_EN
    ,
    output logic [31:0]                     durdur_sayac_o,
    output logic [31:0]                     kabul_sayac_o
`endif
);

    logic [XLEN-1:0]      r_yazmac [YAZMAC_SAYISI];
    logic [SAYAC_BIT-1:0] r_sayac  [YAZMAC_SAYISI];
    logic                 r_hata;

    logic                 w_tehlike;
    logic                 w_dolu;
    logic                 w_kabul;
    logic                 w_rd_gecerli;
    logic [SAYAC_BIT-1:0] w_rd_sayac;
    logic                 w_gy_gecerli;
    logic [SAYAC_BIT-1:0] w_gy_sayac;
    logic                 w_hata_kur;

    // Per-port read value with bypass and busy flag from the pending counter
    for (genvar p = 0; p < OKUMA_PORT; p++) begin : g_port
        logic [ADRES_BIT-1:0] w_adr;
        logic                 w_gecerli;
        logic [SAYAC_BIT-1:0] w_say;
        logic                 w_gy_eslesme;

        assign w_adr        = oku_adres_i[p*ADRES_BIT +: ADRES_BIT];
        assign w_gecerli    = (w_adr != '0) && (32'(w_adr) < 32'(YAZMAC_SAYISI));
        assign w_say        = w_gecerli ? r_sayac[w_adr] : '0;
        assign w_gy_eslesme = gy_yaz_yazmac_i && (gy_yaz_adres_i == w_adr);

        assign oku_deger_o[p*XLEN +: XLEN] = !w_gecerli   ? '0 :
                                             w_gy_eslesme ? gy_yaz_deger_i :
                                                            r_yazmac[w_adr];
        // Busy clears only when this writeback retires the last pending write
        assign oku_mesgul_o[p] = (w_say != '0) &&
                                 !(w_gy_eslesme && (w_say == SAYAC_BIT'(1)));
    end

    // Issue decision: hazard on a used operand, or destination counter saturated
    always_comb begin
        w_rd_gecerli = (rd_adres_i != '0) && (32'(rd_adres_i) < 32'(YAZMAC_SAYISI));
        w_rd_sayac   = w_rd_gecerli ? r_sayac[rd_adres_i] : '0;
        w_tehlike    = |(oku_kullan_i & oku_mesgul_o);
        w_dolu       = rd_yaz_i && (rd_adres_i != '0) && (w_rd_sayac == '1);
        w_kabul      = buyruk_gecerli_i && !ddb_durdur_i && !ddb_bosalt_i &&
                       !w_tehlike && !w_dolu;
        w_gy_gecerli = gy_yaz_yazmac_i && (gy_yaz_adres_i != '0) &&
                       (32'(gy_yaz_adres_i) < 32'(YAZMAC_SAYISI));
        w_gy_sayac   = w_gy_gecerli ? r_sayac[gy_yaz_adres_i] : '0;
        w_hata_kur   = gy_yaz_yazmac_i && (gy_yaz_adres_i != '0) && (w_gy_sayac == '0);
    end

    assign kabul_o          = w_kabul;
    assign puantaj_durdur_o = buyruk_gecerli_i && (w_tehlike || w_dolu);
    assign hata_o           = r_hata;

    // Pending-write counters: reservation increments, writeback decrements
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < YAZMAC_SAYISI; r++) begin
                r_sayac[r] <= '0;
            end
        end else begin
            for (int r = 1; r < YAZMAC_SAYISI; r++) begin
                logic inc;
                logic dec;
                inc = w_kabul && rd_yaz_i && (rd_adres_i == ADRES_BIT'(r));
                dec = gy_yaz_yazmac_i && (gy_yaz_adres_i == ADRES_BIT'(r)) &&
                      (r_sayac[r] != '0);
                if (inc && !dec) begin
                    r_sayac[r] <= r_sayac[r] + SAYAC_BIT'(1);
                end else if (dec && !inc) begin
                    r_sayac[r] <= r_sayac[r] - SAYAC_BIT'(1);
                end
            end
        end
    end

    // Register storage: writeback always lands, x0 stays zero
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < YAZMAC_SAYISI; r++) begin
                r_yazmac[r] <= '0;
            end
        end else if (w_gy_gecerli) begin
            r_yazmac[gy_yaz_adres_i] <= gy_yaz_deger_i;
        end
    end

    // Sticky error: writeback with no outstanding reservation
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hata <= 1'b0;
        end else if (w_hata_kur) begin
            r_hata <= 1'b1;
        end
    end

`ifdef COZ_PUANTAJ_SAYAC_EN
    logic [31:0] r_durdur_sayac;
    logic [31:0] r_kabul_sayac;

    // Saturating stall and issue cycle counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_durdur_sayac <= '0;
            r_kabul_sayac  <= '0;
        end else begin
            if (puantaj_durdur_o && (r_durdur_sayac != '1)) begin
                r_durdur_sayac <= r_durdur_sayac + 32'd1;
            end
            if (w_kabul && (r_kabul_sayac != '1)) begin
                r_kabul_sayac <= r_kabul_sayac + 32'd1;
            end
        end
    end

    assign durdur_sayac_o = r_durdur_sayac;
    assign kabul_sayac_o  = r_kabul_sayac;
`endif

endmodule

// File: tb/tb_coz_yazmac_puantaj.sv
// Testbench for coz_yazmac_puantaj: directed scenarios followed by random
// traffic, all outputs compared every cycle against a behavioural model.
module tb_coz_yazmac_puantaj;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AB   = 5;
    localparam int unsigned NP   = 2;
    localparam int unsigned SB   = 2;
    localparam int          MAKS = (1 << SB) - 1;

    logic               clk;
    logic               rst_n;
    logic [NP*AB-1:0]   oku_adres;
    logic [NP-1:0]      oku_kullan;
    logic [NP*XLEN-1:0] oku_deger;
    logic [NP-1:0]      oku_mesgul;
    logic               buyruk_gecerli;
    logic               rd_yaz;
    logic [AB-1:0]      rd_adres;
    logic               kabul;
    logic               durdur;
    logic               ddb_durdur;
    logic               ddb_bosalt;
    logic               gy_yaz;
    logic [AB-1:0]      gy_adres;
    logic [XLEN-1:0]    gy_deger;
    logic               hata;

    coz_yazmac_puantaj #(
        .XLEN(XLEN), .YAZMAC_SAYISI(NREG), .ADRES_BIT(AB),
        .OKUMA_PORT(NP), .SAYAC_BIT(SB)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .oku_adres_i(oku_adres), .oku_kullan_i(oku_kullan),
        .oku_deger_o(oku_deger), .oku_mesgul_o(oku_mesgul),
        .buyruk_gecerli_i(buyruk_gecerli), .rd_yaz_i(rd_yaz), .rd_adres_i(rd_adres),
        .kabul_o(kabul), .puantaj_durdur_o(durdur),
        .ddb_durdur_i(ddb_durdur), .ddb_bosalt_i(ddb_bosalt),
        .gy_yaz_yazmac_i(gy_yaz), .gy_yaz_adres_i(gy_adres), .gy_yaz_deger_i(gy_deger),
        .hata_o(hata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int hata_say   = 0;
    int kontrol_say = 0;

    // Behavioural model state
    logic [XLEN-1:0] m_reg [NREG];
    int              m_cnt [NREG];
    bit              m_hata;

    task automatic kontrol(input string etiket, input logic [63:0] gozlenen,
                           input logic [63:0] beklenen);
        kontrol_say++;
        if (gozlenen !== beklenen) begin
            hata_say++;
            $display("FAIL %s: got %h expected %h (t=%0t)", etiket, gozlenen, beklenen, $time);
        end
    endtask

    task automatic model_sifirla();
        for (int r = 0; r < NREG; r++) begin
            m_reg[r] = '0;
            m_cnt[r] = 0;
        end
        m_hata = 1'b0;
    endtask

    function automatic logic [XLEN-1:0] m_oku(input int a);
        if (a == 0) return '0;
        if (gy_yaz && int'(gy_adres) == a) return gy_deger;
        return m_reg[a];
    endfunction

    function automatic bit m_mesgul(input int a);
        if (a == 0) return 1'b0;
        if (m_cnt[a] == 0) return 1'b0;
        if (gy_yaz && int'(gy_adres) == a && m_cnt[a] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_kabul();
        bit teh;
        bit dolu;
        teh = 1'b0;
        for (int p = 0; p < NP; p++)
            if (oku_kullan[p] && m_mesgul(int'(oku_adres[p*AB +: AB]))) teh = 1'b1;
        dolu = rd_yaz && rd_adres != 0 && m_cnt[rd_adres] == MAKS;
        return buyruk_gecerli && !ddb_durdur && !ddb_bosalt && !teh && !dolu;
    endfunction

    function automatic bit m_durdur();
        bit teh;
        bit dolu;
        teh = 1'b0;
        for (int p = 0; p < NP; p++)
            if (oku_kullan[p] && m_mesgul(int'(oku_adres[p*AB +: AB]))) teh = 1'b1;
        dolu = rd_yaz && rd_adres != 0 && m_cnt[rd_adres] == MAKS;
        return buyruk_gecerli && (teh || dolu);
    endfunction

    // Compare all outputs against the model for the current inputs
    task automatic bak();
        logic [63:0] bd;
        logic [1:0]  bm;
        #3;
        for (int p = 0; p < NP; p++) begin
            bd[p*XLEN +: XLEN] = m_oku(int'(oku_adres[p*AB +: AB]));
            bm[p]              = m_mesgul(int'(oku_adres[p*AB +: AB]));
        end
        kontrol("deger",  64'(oku_deger),  bd);
        kontrol("mesgul", 64'(oku_mesgul), 64'(bm));
        kontrol("kabul",  64'(kabul),      64'(m_kabul()));
        kontrol("durdur", 64'(durdur),     64'(m_durdur()));
        kontrol("hata",   64'(hata),       64'(m_hata));
    endtask

    // Apply the clock edge to the model, then advance to the next drive point
    task automatic ilerle();
        bit inc;
        bit dec;
        inc = m_kabul() && rd_yaz && rd_adres != 0;
        dec = gy_yaz && gy_adres != 0 && m_cnt[gy_adres] != 0;
        if (gy_yaz && gy_adres != 0 && m_cnt[gy_adres] == 0) m_hata = 1'b1;
        if (inc) m_cnt[rd_adres]++;
        if (dec) m_cnt[gy_adres]--;
        if (gy_yaz && gy_adres != 0) m_reg[gy_adres] = gy_deger;
        @(posedge clk);
        #2;
    endtask

    task automatic bos();
        oku_adres = '0; oku_kullan = '0; buyruk_gecerli = 0; rd_yaz = 0;
        rd_adres = '0; ddb_durdur = 0; ddb_bosalt = 0; gy_yaz = 0;
        gy_adres = '0; gy_deger = '0;
    endtask

    task automatic oku(input int a0, input int a1, input bit k0, input bit k1);
        oku_adres = {AB'(a1), AB'(a0)};
        oku_kullan = {k1, k0};
    endtask

    task automatic buyruk(input bit yaz, input int rd);
        buyruk_gecerli = 1; rd_yaz = yaz; rd_adres = AB'(rd);
    endtask

    task automatic geriyaz(input int a, input logic [XLEN-1:0] d);
        gy_yaz = 1; gy_adres = AB'(a); gy_deger = d;
    endtask

    initial begin
        bos();
        model_sifirla();
        rst_n = 0;
        #12;
        kontrol("rst_hata", 64'(hata), 64'd0);
        kontrol("rst_mesgul", 64'(oku_mesgul), 64'd0);
        rst_n = 1;
        @(posedge clk); #2;

        // Reset state reads
        oku(5, 0, 1, 1); buyruk(0, 0);
        bak();
        kontrol("rst_oku", 64'(oku_deger), 64'd0);
        kontrol("rst_kabul", 64'(kabul), 64'd1);
        ilerle();

        // RAW on x3 resolved by same-cycle writeback
        bos(); buyruk(1, 3); bak(); ilerle();
        bos(); oku(3, 0, 1, 0); buyruk(0, 0); bak();
        kontrol("raw_durdur", 64'(durdur), 64'd1);
        kontrol("raw_kabul0", 64'(kabul), 64'd0);
        ilerle();
        bos(); oku(3, 0, 1, 0); buyruk(0, 0); geriyaz(3, 32'hDEADBEEF); bak();
        kontrol("bypass", 64'(oku_deger[31:0]), 64'hDEADBEEF);
        kontrol("bypass_kabul", 64'(kabul), 64'd1);
        ilerle();

        // Saturate x7 counter
        for (int i = 0; i < 3; i++) begin
            bos(); buyruk(1, 7); bak(); ilerle();
        end
        bos(); buyruk(1, 7); bak();
        kontrol("dolu_durdur", 64'(durdur), 64'd1);
        ilerle();
        bos(); buyruk(1, 7); geriyaz(7, 32'h7); bak(); ilerle();
        bos(); buyruk(1, 7); bak();
        kontrol("dolu_sonra", 64'(kabul), 64'd1);
        ilerle();

        // Simultaneous issue and writeback on x9
        bos(); buyruk(1, 9); bak(); ilerle();
        bos(); buyruk(1, 9); geriyaz(9, 32'h99); bak(); ilerle();
        bos(); oku(9, 9, 1, 0); bak();
        kontrol("x9_mesgul", 64'(oku_mesgul), 64'd3);
        ilerle();

        // Unreserved writeback and x0 writeback
        bos(); geriyaz(4, 32'h12345678); bak(); ilerle();
        bos(); oku(4, 0, 0, 0); geriyaz(0, 32'hFFFFFFFF); bak();
        kontrol("hata_kur", 64'(hata), 64'd1);
        kontrol("x4_oku", 64'(oku_deger), 64'h0000_0000_1234_5678);
        ilerle();
        bos(); oku(0, 4, 0, 0); bak(); ilerle();

        // Flush blocks issue, then asynchronous reset mid-stream
        bos(); buyruk(1, 2); bak(); ilerle();
        bos(); buyruk(1, 2); ddb_bosalt = 1; bak();
        kontrol("bosalt_kabul", 64'(kabul), 64'd0);
        ilerle();
        bos(); oku(2, 2, 0, 0); bak();
        kontrol("x2_mesgul", 64'(oku_mesgul), 64'd3);
        #1 rst_n = 0;
        #1;
        model_sifirla();
        kontrol("arst_hata", 64'(hata), 64'd0);
        kontrol("arst_mesgul", 64'(oku_mesgul), 64'd0);
        #1 rst_n = 1;
        @(posedge clk); #2;

        // Random traffic concentrated on x0..x7
        for (int n = 0; n < 3000; n++) begin
            bos();
            oku($urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 1), $urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) buyruk($urandom_range(0, 3) != 0, $urandom_range(0, 7));
            ddb_durdur = ($urandom_range(0, 9) == 0);
            ddb_bosalt = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 1) == 1) begin
                int a;
                a = $urandom_range(0, 7);
                if ($urandom_range(0, 9) != 0) begin
                    for (int k = 0; k < 8; k++) begin
                        int c;
                        c = (a + k) % 8;
                        if (m_cnt[c] != 0) begin
                            a = c;
                            break;
                        end
                    end
                end
                geriyaz(a, $urandom);
            end
            bak();
            ilerle();
        end

        $display("Result: errors=%0d of %0d checks", hata_say, kontrol_say);
        $finish;
    end

endmodule
